// File: rtl/color_mapping_udiv_44ns_6ns_38_seq_if.sv
// Operand/result handshake bundle for the sequential unsigned divider.
// master drives operands and out_ready; slave is the divider.
interface color_mapping_udiv_44ns_6ns_38_seq_if #(
   parameter int din0_WIDTH = 44,
   parameter int din1_WIDTH = 6,
   parameter int dout_WIDTH = 38
);
   logic                  in_valid;
   logic                  in_ready;
   logic [din0_WIDTH-1:0] din0;
   logic [din1_WIDTH-1:0] din1;
   logic                  out_valid;
   logic                  out_ready;
   logic [dout_WIDTH-1:0] quot;
   logic [din1_WIDTH-1:0] rem;
   logic                  ovf;
   logic                  div_by_zero;

   modport master (
      output in_valid, din0, din1, out_ready,
      input  in_ready, out_valid, quot, rem, ovf, div_by_zero
   );

   modport slave (
      input  in_valid, din0, din1, out_ready,
      output in_ready, out_valid, quot, rem, ovf, div_by_zero
   );
endinterface

// File: rtl/color_mapping_udiv_44ns_6ns_38_seq.sv
// Sequential restoring divider: din0 / din1, one quotient bit per cycle, with overflow bypass.
// Define COLOR_MAPPING_UDIV_ZERO_DETECT_EN to short-circuit zero divisors straight to DONE.
module color_mapping_udiv_44ns_6ns_38_seq #(
   parameter int din0_WIDTH = 44,
   parameter int din1_WIDTH = 6,
   parameter int dout_WIDTH = 38
) (
   input  logic ap_clk,
   input  logic ap_rst_n,
   color_mapping_udiv_44ns_6ns_38_seq_if.slave bus
);
   localparam int            CW   = $clog2(dout_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(dout_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                state_q, state_d;
   logic [dout_WIDTH-1:0] work_q, work_d;
   logic [din1_WIDTH-1:0] prem_q, prem_d;
   logic [din1_WIDTH-1:0] divisor_q, divisor_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  zero_q, zero_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [dout_WIDTH-1:0] quot_q, quot_d;
   logic [din1_WIDTH-1:0] rem_q, rem_d;
   logic                  ovf_q, ovf_d;
   logic                  dbz_q, dbz_d;

   logic [din1_WIDTH:0]   trial, diff;
   logic                  ge;
   logic [din1_WIDTH-1:0] prem_nxt, upper;
   logic [dout_WIDTH-1:0] work_nxt;

   // work_q holds the not-yet-consumed dividend bits; quotient bits enter at the LSB,
   // so after dout_WIDTH shifts it holds exactly the quotient.
   always_comb begin
      trial    = {prem_q, work_q[dout_WIDTH-1]};
      diff     = trial - {1'b0, divisor_q};
      ge       = (trial >= {1'b0, divisor_q});
      prem_nxt = ge ? diff[din1_WIDTH-1:0] : trial[din1_WIDTH-1:0];
      work_nxt = {work_q[dout_WIDTH-2:0], ge};
      upper    = bus.din0[din0_WIDTH-1:dout_WIDTH];
   end

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      prem_d      = prem_q;
      divisor_d   = divisor_q;
      cnt_d       = cnt_q;
      zero_d      = zero_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      ovf_d       = ovf_q;
      dbz_d       = dbz_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               divisor_d  = bus.din1;
               work_d     = bus.din0[dout_WIDTH-1:0];
               prem_d     = upper;
               cnt_d      = '0;
               zero_d     = (bus.din1 == '0);
               in_ready_d = 1'b0;
               if (bus.din1 != '0 && upper >= bus.din1) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  quot_d      = '1;
                  rem_d       = '0;
                  ovf_d       = 1'b1;
                  dbz_d       = 1'b0;
`ifdef COLOR_MAPPING_UDIV_ZERO_DETECT_EN
               end else if (bus.din1 == '0) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  quot_d      = '1;
                  rem_d       = '0;
                  ovf_d       = 1'b0;
                  dbz_d       = 1'b1;
`endif
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            prem_d = prem_nxt;
            work_d = work_nxt;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               quot_d      = work_nxt;
               // a zero divisor degenerates to all-ones quotient; its remainder is meaningless
               rem_d       = zero_q ? '0 : prem_nxt;
               ovf_d       = 1'b0;
               dbz_d       = 1'b0;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= IDLE;
         work_q      <= '0;
         prem_q      <= '0;
         divisor_q   <= '0;
         cnt_q       <= '0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
         ovf_q       <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         prem_q      <= prem_d;
         divisor_q   <= divisor_d;
         cnt_q       <= cnt_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         ovf_q       <= ovf_d;
         dbz_q       <= dbz_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.quot        = quot_q;
   assign bus.rem         = rem_q;
   assign bus.ovf         = ovf_q;
   assign bus.div_by_zero = dbz_q;
endmodule
